// File: rtl/writeback_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : writeback_stage_if
// Brief   : Memory-stage to writeback-stage bundle plus register-file write ports.
// Revision: 1.0
// ============================================================================

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 16
`endif

interface writeback_stage_if #(
    parameter int LANES = 4
);
    logic                      I_LOCK;
    logic                      I_FetchStall;
    logic                      I_DepStall;
    logic [`OPCODE_WIDTH-1:0]  I_Opcode;
    logic [5:0]                I_DestRegIdx;
    logic [`REG_WIDTH-1:0]     I_ALUOut;
    logic [`REG_WIDTH-1:0]     I_MemOut;
    logic [16*LANES-1:0]       I_VALUOut;

    logic                      O_WriteEn;
    logic [5:0]                O_WriteIdx;
    logic [`REG_WIDTH-1:0]     O_WriteData;
    logic                      O_VWriteEn;
    logic [5:0]                O_VWriteIdx;
    logic [1:0]                O_VWriteLane;
    logic [15:0]               O_VWriteData;
    logic                      O_WBStall;
    logic                      O_Overflow;
`ifdef WB_PERF_EN
    logic [15:0]               O_RetireCount;
    logic [15:0]               O_StallCycles;
`endif

    modport master (
`ifdef WB_PERF_EN
        input  O_RetireCount,
        input  O_StallCycles,
`endif
        output I_LOCK, I_FetchStall, I_DepStall, I_Opcode, I_DestRegIdx,
        output I_ALUOut, I_MemOut, I_VALUOut,
        input  O_WriteEn, O_WriteIdx, O_WriteData,
        input  O_VWriteEn, O_VWriteIdx, O_VWriteLane, O_VWriteData,
        input  O_WBStall, O_Overflow
    );

    modport slave (
`ifdef WB_PERF_EN
        output O_RetireCount,
        output O_StallCycles,
`endif
        input  I_LOCK, I_FetchStall, I_DepStall, I_Opcode, I_DestRegIdx,
        input  I_ALUOut, I_MemOut, I_VALUOut,
        output O_WriteEn, O_WriteIdx, O_WriteData,
        output O_VWriteEn, O_VWriteIdx, O_VWriteLane, O_VWriteData,
        output O_WBStall, O_Overflow
    );
endinterface

`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module  : writeback_stage
// Brief   : Scalar retire port plus queued, lane-serial vector register writes.
//           Optional WB_PERF_EN adds retire and stall-cycle counters.
// Revision: 1.0
// ============================================================================

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 16
`endif

module writeback_stage #(
    parameter int VQ_DEPTH = 2,
    parameter int LANES    = 4
) (
    input  wire logic        I_CLOCK,
    input  wire logic        I_RESET_N,
    writeback_stage_if.slave bus
);
    localparam int OP_W  = `OPCODE_WIDTH;
    localparam int VW    = 16 * LANES;
    localparam int PTR_W = (VQ_DEPTH > 1) ? $clog2(VQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(VQ_DEPTH + 1);

    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(VQ_DEPTH);
    localparam logic [CNT_W-1:0] c_depth_m1 = CNT_W'(VQ_DEPTH - 1);

    localparam logic [OP_W-1:0] c_op_add       = OP_W'(8'h00);
    localparam logic [OP_W-1:0] c_op_addi      = OP_W'(8'h01);
    localparam logic [OP_W-1:0] c_op_and       = OP_W'(8'h02);
    localparam logic [OP_W-1:0] c_op_andi      = OP_W'(8'h03);
    localparam logic [OP_W-1:0] c_op_mov       = OP_W'(8'h04);
    localparam logic [OP_W-1:0] c_op_movi      = OP_W'(8'h05);
    localparam logic [OP_W-1:0] c_op_ldw       = OP_W'(8'h06);
    localparam logic [OP_W-1:0] c_op_vadd      = OP_W'(8'h10);
    localparam logic [OP_W-1:0] c_op_vmov      = OP_W'(8'h11);
    localparam logic [OP_W-1:0] c_op_vmovi     = OP_W'(8'h12);
    localparam logic [OP_W-1:0] c_op_vcompmov  = OP_W'(8'h13);
    localparam logic [OP_W-1:0] c_op_vcompmovi = OP_W'(8'h14);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        w_count_next;
    logic [5:0]              r_q_idx  [VQ_DEPTH];
    logic [VW-1:0]           r_q_data [VQ_DEPTH];
    logic [LANES-1:0]        r_q_mask [VQ_DEPTH];

    logic                    r_wr_en;
    logic [5:0]              r_wr_idx;
    logic [`REG_WIDTH-1:0]   r_wr_data;
    logic                    r_vwr_en;
    logic [5:0]              r_vwr_idx;
    logic [1:0]              r_vwr_lane;
    logic [15:0]             r_vwr_data;
    logic                    r_wb_stall;
    logic                    r_overflow;

    logic                    w_commit;
    logic                    w_is_scalar;
    logic                    w_is_vfull;
    logic                    w_is_vcomp;
    logic                    w_is_vec;
    logic                    w_drain;
    logic [LANES-1:0]        w_head_mask;
    logic [1:0]              w_lane;
    logic [LANES-1:0]        w_mask_rest;
    logic [15:0]             w_lane_data;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;
    logic [LANES-1:0]        w_push_mask;

    assign w_commit    = bus.I_LOCK && !bus.I_FetchStall && !bus.I_DepStall;
    assign w_is_scalar = (bus.I_Opcode == c_op_add)  || (bus.I_Opcode == c_op_addi) ||
                         (bus.I_Opcode == c_op_and)  || (bus.I_Opcode == c_op_andi) ||
                         (bus.I_Opcode == c_op_mov)  || (bus.I_Opcode == c_op_movi) ||
                         (bus.I_Opcode == c_op_ldw);
    assign w_is_vfull  = (bus.I_Opcode == c_op_vadd) || (bus.I_Opcode == c_op_vmov) ||
                         (bus.I_Opcode == c_op_vmovi);
    assign w_is_vcomp  = (bus.I_Opcode == c_op_vcompmov) || (bus.I_Opcode == c_op_vcompmovi);
    assign w_is_vec    = w_is_vfull || w_is_vcomp;
    assign w_push_mask = w_is_vcomp ? (LANES'(1) << bus.I_ALUOut[1:0]) : {LANES{1'b1}};

    // Drain FSM: next state, lane selection and pop decision.
    always_comb begin
        w_state_next = r_state;
        w_drain      = (r_state == S_DRAIN);
        w_head_mask  = r_q_mask[r_rd_ptr];
        w_lane       = 2'd0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (w_head_mask[i]) begin
                w_lane = 2'(i);
            end
        end
        w_mask_rest = w_head_mask & ~(LANES'(1) << w_lane);
        w_lane_data = r_q_data[r_rd_ptr][16*int'(w_lane) +: 16];
        w_pop       = w_drain && (w_mask_rest == '0);
        // A full queue still accepts a push when the head leaves on the same edge.
        w_push      = w_commit && w_is_vec && ((r_count != c_depth) || w_pop);
        w_drop      = w_commit && w_is_vec && (r_count == c_depth) && !w_pop;

        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CNT_W'(1);
        end

        case (r_state)
            S_IDLE:  if (w_count_next != '0) w_state_next = S_DRAIN;
            S_DRAIN: if (w_count_next == '0) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_state    <= S_IDLE;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < VQ_DEPTH; i++) begin
                r_q_idx[i]  <= '0;
                r_q_data[i] <= '0;
                r_q_mask[i] <= '0;
            end
            r_wr_en    <= 1'b0;
            r_wr_idx   <= '0;
            r_wr_data  <= '0;
            r_vwr_en   <= 1'b0;
            r_vwr_idx  <= '0;
            r_vwr_lane <= '0;
            r_vwr_data <= '0;
            r_wb_stall <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end else if (w_drain) begin
                r_q_mask[r_rd_ptr] <= w_mask_rest;
            end

            // Placed after the mask update so a push into the slot being popped wins.
            if (w_push) begin
                r_q_idx[r_wr_ptr]  <= bus.I_DestRegIdx;
                r_q_data[r_wr_ptr] <= bus.I_VALUOut;
                r_q_mask[r_wr_ptr] <= w_push_mask;
                r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
            end

            r_wr_en <= w_commit && w_is_scalar;
            if (w_commit && w_is_scalar) begin
                r_wr_idx  <= bus.I_DestRegIdx;
                r_wr_data <= (bus.I_Opcode == c_op_ldw) ? bus.I_MemOut : bus.I_ALUOut;
            end

            r_vwr_en <= w_drain;
            if (w_drain) begin
                r_vwr_idx  <= r_q_idx[r_rd_ptr];
                r_vwr_lane <= w_lane;
                r_vwr_data <= w_lane_data;
            end

            r_wb_stall <= (w_count_next >= c_depth_m1);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef WB_PERF_EN
    logic [15:0] r_retire_count;
    logic [15:0] r_stall_cycles;

    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_retire_count <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_commit) begin
                r_retire_count <= r_retire_count + 16'd1;
            end
            if (r_wb_stall && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

    assign bus.O_RetireCount = r_retire_count;
    assign bus.O_StallCycles = r_stall_cycles;
`endif

    assign bus.O_WriteEn    = r_wr_en;
    assign bus.O_WriteIdx   = r_wr_idx;
    assign bus.O_WriteData  = r_wr_data;
    assign bus.O_VWriteEn   = r_vwr_en;
    assign bus.O_VWriteIdx  = r_vwr_idx;
    assign bus.O_VWriteLane = r_vwr_lane;
    assign bus.O_VWriteData = r_vwr_data;
    assign bus.O_WBStall    = r_wb_stall;
    assign bus.O_Overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_writeback_stage
// Brief   : Directed self-checking bench for writeback_stage (VQ_DEPTH=2, LANES=4).
// Revision: 1.0
// ============================================================================

module tb_writeback_stage;
    localparam logic [7:0] OP_ADD      = 8'h00;
    localparam logic [7:0] OP_ADDI     = 8'h01;
    localparam logic [7:0] OP_MOVI     = 8'h05;
    localparam logic [7:0] OP_LDW      = 8'h06;
    localparam logic [7:0] OP_STW      = 8'h07;
    localparam logic [7:0] OP_VADD     = 8'h10;
    localparam logic [7:0] OP_VMOV     = 8'h11;
    localparam logic [7:0] OP_VMOVI    = 8'h12;
    localparam logic [7:0] OP_VCOMPMOV = 8'h13;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   stall_seen = 0;

    always #5 clk = ~clk;

    writeback_stage_if #(.LANES(4)) bus();

    writeback_stage #(.VQ_DEPTH(2), .LANES(4)) dut (
        .I_CLOCK   (clk),
        .I_RESET_N (rst_n),
        .bus       (bus)
    );

    always @(posedge clk) begin
        if (!rst_n) stall_seen <= 0;
        else if (bus.O_WBStall) stall_seen <= stall_seen + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs set before tick are taken at the negedge; outputs are read at the following posedge.
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic drive(input logic [7:0] op, input logic [5:0] idx, input logic [15:0] alu,
                         input logic [15:0] mem, input logic [63:0] valu);
        bus.I_LOCK       = 1'b1;
        bus.I_FetchStall = 1'b0;
        bus.I_DepStall   = 1'b0;
        bus.I_Opcode     = op;
        bus.I_DestRegIdx = idx;
        bus.I_ALUOut     = alu;
        bus.I_MemOut     = mem;
        bus.I_VALUOut    = valu;
    endtask

    task automatic idle();
        bus.I_LOCK = 1'b0;
    endtask

    task automatic expect_vw(input string tag, input logic en, input logic [5:0] idx,
                             input logic [1:0] lane, input logic [15:0] data);
        check({tag, ".ven"}, 64'(bus.O_VWriteEn), 64'(en));
        if (en) begin
            check({tag, ".vidx"},  64'(bus.O_VWriteIdx),  64'(idx));
            check({tag, ".vlane"}, 64'(bus.O_VWriteLane), 64'(lane));
            check({tag, ".vdata"}, 64'(bus.O_VWriteData), 64'(data));
        end
    endtask

    initial begin
        logic [15:0] exp_d [4];
        int          n_res;
        exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h3333; exp_d[3] = 16'h4444;

        drive(OP_STW, 6'd0, 16'h0, 16'h0, 64'h0);
        idle();
        repeat (2) @(posedge clk);

        check("rst.wen",   64'(bus.O_WriteEn),    64'd0);
        check("rst.widx",  64'(bus.O_WriteIdx),   64'd0);
        check("rst.wdata", 64'(bus.O_WriteData),  64'd0);
        check("rst.ven",   64'(bus.O_VWriteEn),   64'd0);
        check("rst.vdata", 64'(bus.O_VWriteData), 64'd0);
        check("rst.stall", 64'(bus.O_WBStall),    64'd0);
        check("rst.ovf",   64'(bus.O_Overflow),   64'd0);
`ifdef WB_PERF_EN
        check("rst.retire", 64'(bus.O_RetireCount), 64'd0);
        check("rst.stcyc",  64'(bus.O_StallCycles), 64'd0);
`endif
        rst_n = 1'b1;

        // LDW writes load data, not ALU result; strobe lasts one cycle.
        drive(OP_LDW, 6'd3, 16'h00FF, 16'h1234, 64'h0);
        tick();
        check("ldw.wen",   64'(bus.O_WriteEn),   64'd1);
        check("ldw.widx",  64'(bus.O_WriteIdx),  64'd3);
        check("ldw.wdata", 64'(bus.O_WriteData), 64'h1234);
        check("ldw.ven",   64'(bus.O_VWriteEn),  64'd0);
        idle();
        tick();
        check("ldw.pulse", 64'(bus.O_WriteEn),   64'd0);

        // Bubbles and non-writing opcode.
        drive(OP_ADDI, 6'd5, 16'h0055, 16'h0, 64'h0);
        bus.I_DepStall = 1'b1;
        tick();
        check("dep.wen", 64'(bus.O_WriteEn), 64'd0);
        bus.I_DepStall   = 1'b0;
        bus.I_FetchStall = 1'b1;
        tick();
        check("fetch.wen", 64'(bus.O_WriteEn), 64'd0);
        bus.I_FetchStall = 1'b0;
        tick();
        check("addi.wen",   64'(bus.O_WriteEn),   64'd1);
        check("addi.widx",  64'(bus.O_WriteIdx),  64'd5);
        check("addi.wdata", 64'(bus.O_WriteData), 64'h0055);
        drive(OP_STW, 6'd8, 16'h7777, 16'h8888, 64'h0);
        tick();
        check("stw.wen", 64'(bus.O_WriteEn), 64'd0);
        check("stw.ven", 64'(bus.O_VWriteEn), 64'd0);

        // Full-vector drain with a scalar commit overlapping lane 1.
        drive(OP_VADD, 6'd2, 16'h0, 16'h0, 64'h4444_3333_2222_1111);
        tick();
        check("vadd.push.ven", 64'(bus.O_VWriteEn), 64'd0);
        check("vadd.push.stall", 64'(bus.O_WBStall), 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) drive(OP_ADD, 6'd6, 16'h0ABC, 16'h0, 64'h0);
            else        idle();
            tick();
            expect_vw($sformatf("vadd.l%0d", i), 1'b1, 6'd2, 2'(i), exp_d[i]);
            check($sformatf("vadd.l%0d.stall", i), 64'(bus.O_WBStall), (i == 3) ? 64'd0 : 64'd1);
            check($sformatf("vadd.l%0d.wen", i), 64'(bus.O_WriteEn), (i == 1) ? 64'd1 : 64'd0);
            if (i == 1) check("vadd.sc.wdata", 64'(bus.O_WriteData), 64'h0ABC);
        end
        idle();
        tick();
        check("vadd.idle.ven",   64'(bus.O_VWriteEn),   64'd0);
        check("vadd.hold.lane",  64'(bus.O_VWriteLane), 64'd3);
        check("vadd.hold.vdata", 64'(bus.O_VWriteData), 64'h4444);

        // Back-to-back entries and overflow with a two-entry queue.
        check("b2b.ovf0", 64'(bus.O_Overflow), 64'd0);
        drive(OP_VMOVI, 6'd7, 16'h0, 16'h0, 64'hDDDD_CCCC_BBBB_AAAA);
        tick();
        expect_vw("b2b.e0", 1'b0, 6'd0, 2'd0, 16'h0);
        drive(OP_VCOMPMOV, 6'd9, 16'h0002, 16'h0, 64'h8888_7777_6666_5555);
        tick();
        expect_vw("b2b.e1", 1'b1, 6'd7, 2'd0, 16'hAAAA);
        check("b2b.e1.ovf", 64'(bus.O_Overflow), 64'd0);
        drive(OP_VMOV, 6'd11, 16'h0, 16'h0, 64'hFFFF_EEEE_9999_0123);
        tick();
        expect_vw("b2b.e2", 1'b1, 6'd7, 2'd1, 16'hBBBB);
        check("b2b.e2.ovf", 64'(bus.O_Overflow), 64'd1);
        idle();
        tick();
        expect_vw("b2b.e3", 1'b1, 6'd7, 2'd2, 16'hCCCC);
        tick();
        expect_vw("b2b.e4", 1'b1, 6'd7, 2'd3, 16'hDDDD);
        tick();
        expect_vw("b2b.e5", 1'b1, 6'd9, 2'd2, 16'h7777);
        tick();
        expect_vw("b2b.e6", 1'b0, 6'd0, 2'd0, 16'h0);
        check("b2b.e6.ovf", 64'(bus.O_Overflow), 64'd1);

        // Reset asserted while lane 1 is on the port.
        drive(OP_VADD, 6'd4, 16'h0, 16'h0, 64'h9999_8888_7777_6666);
        tick();
        idle();
        tick();
        tick();
        expect_vw("rmd.l1", 1'b1, 6'd4, 2'd1, 16'h7777);
        rst_n = 1'b0;
        #1;
        check("rmd.ven",   64'(bus.O_VWriteEn),    64'd0);
        check("rmd.vidx",  64'(bus.O_VWriteIdx),   64'd0);
        check("rmd.vlane", 64'(bus.O_VWriteLane),  64'd0);
        check("rmd.vdata", 64'(bus.O_VWriteData),  64'd0);
        check("rmd.ovf",   64'(bus.O_Overflow),    64'd0);
        check("rmd.stall", 64'(bus.O_WBStall),     64'd0);
        tick();
        rst_n = 1'b1;
        n_res = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.O_VWriteEn) n_res++;
        end
        check("rmd.residual", 64'(n_res), 64'd0);

`ifdef WB_PERF_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(OP_ADD, 6'd1, 16'h0011, 16'h0, 64'h0);
        tick();
        drive(OP_MOVI, 6'd2, 16'h0022, 16'h0, 64'h0);
        tick();
        drive(OP_LDW, 6'd3, 16'h0, 16'h0033, 64'h0);
        tick();
        drive(OP_VMOV, 6'd12, 16'h0, 16'h0, 64'h0004_0003_0002_0001);
        tick();
        idle();
        repeat (6) tick();
        check("perf.retire",    64'(bus.O_RetireCount), 64'd4);
        check("perf.stcyc",     64'(bus.O_StallCycles), 64'd4);
        check("perf.stcyc.obs", 64'(bus.O_StallCycles), 64'(stall_seen));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
